// File: rtl/i2c_slave_pkg.sv
// i2c_slave_pkg
// Shared types for the single-address I2C target.
//   st_e      : protocol state of the target FSM
//   BIT_CNT_W : width of the per-byte bit counter (counts 0..7)
package i2c_slave_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ACK_ADDR,
        RX_DATA,
        ACK_RX,
        TX_DATA,
        MACK,
        WAIT_STOP
    } st_e;

    localparam int BIT_CNT_W = 3;

endpackage

// File: rtl/i2c_line_sync.sv
// i2c_line_sync
// Synchronizes one asynchronous bus line into the clk domain and flags its edges.
// Ports:
//   clk, reset : system clock, asynchronous active-high reset
//   line_in    : raw bus line
//   level      : synchronized line level
//   rise, fall : single-cycle edge flags derived from the synchronized copy
module i2c_line_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic line_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // Flops reset to 1 because an idle I2C bus is pulled high; this avoids
    // a phantom edge (or START/STOP) right after reset is released.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], line_in};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = level & ~prev_q;
    assign fall  = ~level & prev_q;

endmodule

// File: rtl/i2c_slave.sv
// i2c_slave
// Single-address I2C target: oversamples SCL/SDA, detects START/STOP, matches
// DEV_ADDR, delivers write bytes on a strobe and shifts read bytes out.
// Ports:
//   clk, reset : system clock (>= 8x SCL), asynchronous active-high reset
//   i2c_scl    : bus clock (never stretched)
//   i2c_sda    : open-drain bus data, only driven low or released
//   tx_data    : next read byte, sampled when tx_req pulses
//   tx_req     : 1-cycle pulse when tx_data is loaded into the shifter
//   rx_data    : last received write byte
//   rx_valid   : 1-cycle pulse when rx_data updates
//   busy       : high from address match until STOP / repeated START
module i2c_slave #(
    parameter logic [6:0] DEV_ADDR    = 7'h50,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i2c_scl,
    inout  wire        i2c_sda,
    input  logic [7:0] tx_data,
    output logic       tx_req,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       busy
);
    import i2c_slave_pkg::*;

    logic scl_level, scl_rise, scl_fall;
    logic sda_level, sda_rise, sda_fall;

    i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_scl_sync (
        .clk(clk), .reset(reset), .line_in(i2c_scl),
        .level(scl_level), .rise(scl_rise), .fall(scl_fall)
    );

    i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sda_sync (
        .clk(clk), .reset(reset), .line_in(i2c_sda),
        .level(sda_level), .rise(sda_rise), .fall(sda_fall)
    );

    // Bus conditions: SDA may only move while SCL is high at START/STOP.
    logic start_det, stop_det;
    assign start_det = scl_level & sda_fall;
    assign stop_det  = scl_level & sda_rise;

    st_e                  state, state_nxt;
    logic [7:0]           shifter, shifter_nxt;
    logic [BIT_CNT_W-1:0] bit_cnt, bit_cnt_nxt;
    logic                 sda_low, sda_low_nxt;
    logic                 rw, rw_nxt;
    logic                 mack_seen, mack_seen_nxt;
    logic [7:0]           rx_data_nxt;
    logic                 rx_valid_nxt, tx_req_nxt, busy_nxt;
    logic [7:0]           shift_in;

    assign shift_in = {shifter[6:0], sda_level};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            shifter   <= 8'h00;
            bit_cnt   <= '0;
            sda_low   <= 1'b0;
            rw        <= 1'b0;
            mack_seen <= 1'b0;
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
            tx_req    <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            shifter   <= shifter_nxt;
            bit_cnt   <= bit_cnt_nxt;
            sda_low   <= sda_low_nxt;
            rw        <= rw_nxt;
            mack_seen <= mack_seen_nxt;
            rx_data   <= rx_data_nxt;
            rx_valid  <= rx_valid_nxt;
            tx_req    <= tx_req_nxt;
            busy      <= busy_nxt;
        end
    end

    // STOP/START override every state, so an edge seen in the same cycle is
    // dropped. ACK phases use sda_low itself to tell the first falling edge
    // (start driving) from the second (release).
    always_comb begin
        state_nxt     = state;
        shifter_nxt   = shifter;
        bit_cnt_nxt   = bit_cnt;
        sda_low_nxt   = sda_low;
        rw_nxt        = rw;
        mack_seen_nxt = mack_seen;
        rx_data_nxt   = rx_data;
        rx_valid_nxt  = 1'b0;
        tx_req_nxt    = 1'b0;
        busy_nxt      = busy;

        if (stop_det) begin
            state_nxt   = IDLE;
            sda_low_nxt = 1'b0;
            busy_nxt    = 1'b0;
            bit_cnt_nxt = '0;
        end else if (start_det) begin
            state_nxt   = ADDR;
            sda_low_nxt = 1'b0;
            busy_nxt    = 1'b0;
            bit_cnt_nxt = '0;
            shifter_nxt = 8'h00;
        end else begin
            case (state)
                ADDR: begin
                    if (scl_rise) begin
                        shifter_nxt = shift_in;
                        bit_cnt_nxt = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            // General call (7'h00) is never acknowledged.
                            if (shift_in[7:1] == DEV_ADDR && shift_in[7:1] != 7'h00) begin
                                state_nxt = ACK_ADDR;
                                busy_nxt  = 1'b1;
                                rw_nxt    = shift_in[0];
                            end else begin
                                state_nxt = WAIT_STOP;
                            end
                        end
                    end
                end
                ACK_ADDR: begin
                    if (scl_fall) begin
                        if (!sda_low) begin
                            sda_low_nxt = 1'b1;
                        end else if (rw) begin
                            state_nxt   = TX_DATA;
                            shifter_nxt = tx_data;
                            tx_req_nxt  = 1'b1;
                            sda_low_nxt = ~tx_data[7];
                            bit_cnt_nxt = '0;
                        end else begin
                            state_nxt   = RX_DATA;
                            sda_low_nxt = 1'b0;
                            bit_cnt_nxt = '0;
                        end
                    end
                end
                RX_DATA: begin
                    if (scl_rise) begin
                        shifter_nxt = shift_in;
                        bit_cnt_nxt = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            rx_data_nxt  = shift_in;
                            rx_valid_nxt = 1'b1;
                            state_nxt    = ACK_RX;
                        end
                    end
                end
                ACK_RX: begin
                    if (scl_fall) begin
                        if (!sda_low) begin
                            sda_low_nxt = 1'b1;
                        end else begin
                            sda_low_nxt = 1'b0;
                            state_nxt   = RX_DATA;
                            bit_cnt_nxt = '0;
                        end
                    end
                end
                TX_DATA: begin
                    // The MSB was driven at load time; each falling edge
                    // presents the next bit, the 8th one releases the line.
                    if (scl_fall) begin
                        if (bit_cnt == 3'd7) begin
                            sda_low_nxt   = 1'b0;
                            state_nxt     = MACK;
                            mack_seen_nxt = 1'b0;
                        end else begin
                            shifter_nxt = {shifter[6:0], 1'b0};
                            sda_low_nxt = ~shifter[6];
                            bit_cnt_nxt = bit_cnt + 3'd1;
                        end
                    end
                end
                MACK: begin
                    if (scl_rise) begin
                        if (!sda_level) begin
                            mack_seen_nxt = 1'b1;
                        end else begin
                            state_nxt = WAIT_STOP;
                        end
                    end else if (scl_fall && mack_seen) begin
                        state_nxt   = TX_DATA;
                        shifter_nxt = tx_data;
                        tx_req_nxt  = 1'b1;
                        sda_low_nxt = ~tx_data[7];
                        bit_cnt_nxt = '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Gating with reset releases the line combinationally, not at the next edge.
    assign i2c_sda = (sda_low && !reset) ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_i2c_slave.sv
// tb_i2c_slave
// Bit-banged I2C master driving i2c_slave, checked against a transaction-level
// model: a target at 7'h50 ACKs its address and every write byte, reports each
// written byte once, and returns the offered read bytes MSB-first.
module tb_i2c_slave;

    localparam logic [6:0] ADDR = 7'h50;
    localparam int Q = 10;

    logic       clk = 1'b0;
    logic       reset;
    logic       scl;
    logic       master_low;
    logic [7:0] tx_data;
    wire        tx_req;
    wire  [7:0] rx_data;
    wire        rx_valid;
    wire        busy;
    wire        sda_bus;

    pullup (sda_bus);
    assign sda_bus = master_low ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    i2c_slave #(.DEV_ADDR(ADDR), .SYNC_STAGES(2)) dut (
        .clk(clk),
        .reset(reset),
        .i2c_scl(scl),
        .i2c_sda(sda_bus),
        .tx_data(tx_data),
        .tx_req(tx_req),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .busy(busy)
    );

    int checks = 0;
    int errors = 0;
    int txreq_count = 0;
    logic [7:0] rx_log[$];
    logic [7:0] wdata[3];
    logic [7:0] tdata[4];

    // Observer: records every write byte strobe and every read-byte request.
    always @(negedge clk) begin
        if (rx_valid) rx_log.push_back(rx_data);
        if (tx_req) txreq_count++;
    end

    initial begin
        #(3_000_000);
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic waitClks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Works from an idle bus and as a repeated START from SCL low.
    task automatic busStart();
        master_low = 1'b0;
        waitClks(Q);
        scl = 1'b1;
        waitClks(Q);
        master_low = 1'b1;
        waitClks(Q);
        scl = 1'b0;
        waitClks(Q);
    endtask

    task automatic busStop();
        master_low = 1'b1;
        waitClks(Q);
        scl = 1'b1;
        waitClks(Q);
        master_low = 1'b0;
        waitClks(2 * Q);
    endtask

    task automatic clockBit(input logic b, output logic s);
        master_low = ~b;
        waitClks(Q);
        scl = 1'b1;
        waitClks(Q);
        s = sda_bus;
        waitClks(Q);
        scl = 1'b0;
        waitClks(Q);
    endtask

    task automatic sendByte(input logic [7:0] d, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) clockBit(d[i], s);
        clockBit(1'b1, s);
        ack = ~s;
    endtask

    task automatic recvByte(input logic ack_it, input logic [7:0] next_tx, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            clockBit(1'b1, s);
            d[i] = s;
        end
        tx_data = next_tx;
        clockBit(~ack_it, s);
    endtask

    // Write transaction with wdata[0..n-1]; the master keeps clocking even
    // after a NACK so that an ignoring target can be observed.
    task automatic writeTxn(input logic [6:0] a, input int n);
        logic ack;
        logic exp_ack;
        int   base;
        exp_ack = (a == ADDR);
        base = rx_log.size();
        busStart();
        sendByte({a, 1'b0}, ack);
        checkOutput("addr_ack_w", ack, exp_ack);
        checkOutput("busy_after_addr", busy, exp_ack);
        for (int k = 0; k < n; k++) begin
            sendByte(wdata[k], ack);
            checkOutput("data_ack", ack, exp_ack);
        end
        busStop();
        checkOutput("busy_after_stop", busy, 1'b0);
        checkOutput("rx_count", rx_log.size() - base, exp_ack ? n : 0);
        if (exp_ack) begin
            for (int k = 0; k < n; k++) checkOutput("rx_byte", rx_log[base + k], wdata[k]);
            checkOutput("rx_data_held", rx_data, wdata[n - 1]);
        end
    endtask

    // Read transaction returning tdata[0..n-1]; master ACKs all but the last.
    task automatic readTxn(input logic [6:0] a, input int n);
        logic       ack;
        logic       exp_ack;
        logic [7:0] d;
        int         base_req;
        int         base_rx;
        exp_ack  = (a == ADDR);
        base_req = txreq_count;
        base_rx  = rx_log.size();
        tx_data  = tdata[0];
        busStart();
        sendByte({a, 1'b1}, ack);
        checkOutput("addr_ack_r", ack, exp_ack);
        for (int k = 0; k < n; k++) begin
            recvByte(k != n - 1, tdata[k + 1], d);
            checkOutput("read_byte", d, exp_ack ? tdata[k] : 8'hFF);
        end
        checkOutput("sda_released_nack", sda_bus, 1'b1);
        busStop();
        checkOutput("tx_req_count", txreq_count - base_req, exp_ack ? n : 0);
        checkOutput("no_rx_on_read", rx_log.size() - base_rx, 0);
    endtask

    task automatic applyStimulus(input int iters);
        logic [6:0] a;
        int         n;
        for (int it = 0; it < iters; it++) begin
            case ($urandom_range(0, 3))
                0: a = ADDR;
                1: a = 7'h51;
                2: a = 7'h00;
                default: a = 7'($urandom);
            endcase
            n = $urandom_range(1, 3);
            for (int k = 0; k < 3; k++) wdata[k] = 8'($urandom);
            for (int k = 0; k < 4; k++) tdata[k] = 8'($urandom);
            if ($urandom_range(0, 1) == 1) readTxn(a, n);
            else writeTxn(a, n);
        end
    endtask

    initial begin
        logic       ack;
        logic       s;
        logic [7:0] d;
        int         base_rx;

        reset = 1'b1;
        scl = 1'b1;
        master_low = 1'b0;
        tx_data = 8'h00;
        waitClks(3);
        checkOutput("reset_busy", busy, 1'b0);
        checkOutput("reset_rx_data", rx_data, 8'h00);
        checkOutput("reset_rx_valid", rx_valid, 1'b0);
        checkOutput("reset_tx_req", tx_req, 1'b0);
        checkOutput("reset_sda", sda_bus, 1'b1);
        reset = 1'b0;
        waitClks(5);

        // Write A5, 3C to the target.
        wdata[0] = 8'hA5;
        wdata[1] = 8'h3C;
        writeTxn(ADDR, 2);

        // Wrong address, then general call, then a matching write.
        wdata[0] = 8'h77;
        writeTxn(7'h51, 1);
        writeTxn(7'h00, 1);
        wdata[0] = 8'h12;
        writeTxn(ADDR, 1);

        // Read C3 then 0F with master ACK then NACK.
        tdata[0] = 8'hC3;
        tdata[1] = 8'h0F;
        tdata[2] = 8'hEE;
        readTxn(ADDR, 2);

        // Repeated START after 4 bits of a write byte, then a read.
        base_rx = rx_log.size();
        busStart();
        sendByte({ADDR, 1'b0}, ack);
        checkOutput("rs_addr_ack", ack, 1'b1);
        for (int i = 0; i < 4; i++) clockBit(i[0], s);
        tdata[0] = 8'h5A;
        tdata[1] = 8'h00;
        readTxn(ADDR, 1);
        checkOutput("rs_no_partial_rx", rx_log.size() - base_rx, 0);

        // Reset while the target pulls SDA low for a 0 MSB.
        busStart();
        tx_data = 8'h00;
        sendByte({ADDR, 1'b1}, ack);
        checkOutput("rst_addr_ack", ack, 1'b1);
        checkOutput("rst_msb_low", sda_bus, 1'b0);
        reset = 1'b1;
        #1;
        checkOutput("rst_sda_release", sda_bus, 1'b1);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_rx_data", rx_data, 8'h00);
        checkOutput("rst_tx_req", tx_req, 1'b0);
        checkOutput("rst_rx_valid", rx_valid, 1'b0);
        waitClks(3);
        reset = 1'b0;
        busStop();
        wdata[0] = 8'h9C;
        wdata[1] = 8'h01;
        writeTxn(ADDR, 2);

        applyStimulus(14);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/i2c_slave.md
# i2c_slave

Single-address I2C target that responds to the bus traffic issued by the team's `i2c_master`. It oversamples SCL/SDA on the system clock, detects START/STOP, and matches the 7-bit address. Write bytes are delivered on a strobe interface; read bytes are shifted out from a byte-wide input. SDA is open-drain: the block only ever pulls low or releases.

## Interface
Parameters:
- `DEV_ADDR`, 7'h50, 7-bit address this target answers to.
- `SYNC_STAGES`, 2, synchronizer depth on SCL and SDA (minimum 2).

Ports:
- `clk`  in  1  system clock. Must be at least 8× the SCL frequency.
- `reset`  in  1  asynchronous, active-high reset.
- `i2c_scl`  in  1  bus clock; the target never stretches it.
- `i2c_sda`  inout  1  bus data. Driven 0 or released to 'z; never driven 1.
- `tx_data`  in  8  next read byte; sampled when `tx_req` pulses.
- `tx_req`  out  1  1-cycle pulse when `tx_data` is loaded into the shifter.
- `rx_data`  out  8  last received write byte; held until the next byte arrives.
- `rx_valid`  out  1  1-cycle pulse when `rx_data` updates.
- `busy`  out  1  high from an address match until STOP or a repeated START.

## Operation
Synchronization and edge detection:
- SCL and SDA pass through `SYNC_STAGES` flops.
- Rising and falling edges of SCL are detected on the synchronized copies.
- START = SDA falls while SCL is high. STOP = SDA rises while SCL is high. Both are checked every cycle and take priority over all states.

State machine (`st_e`):
- IDLE: wait for START, then go to ADDR with bit count 0.
- ADDR: shift 8 bits MSB-first on SCL rising edges (7 address bits + R/W).
  - After bit 8: address == `DEV_ADDR` → ACK_ADDR. Otherwise → WAIT_STOP, with no ACK driven.
  - Address 7'h00 (general call) is unsupported and treated as a mismatch.
- ACK_ADDR: pull SDA low from the next SCL falling edge until the following SCL falling edge.
  - On release: R/W = 0 → RX_DATA.
  - R/W = 1 → load `tx_data`, pulse `tx_req`, drive the MSB, go to TX_DATA.
- RX_DATA: shift 8 bits on SCL rising edges. After bit 8, update `rx_data`, pulse `rx_valid`, go to ACK_RX.
- ACK_RX: same ACK timing as ACK_ADDR, then → RX_DATA. No byte limit.
- TX_DATA:
  - Change SDA only on SCL falling edges, MSB first.
  - Bit = 0 → pull low; bit = 1 → release.
  - After bit 8, release SDA and go to MACK.
- MACK: sample SDA on the SCL rising edge.
  - 0 (ACK) → on the next SCL falling edge, load `tx_data`, pulse `tx_req`, drive the MSB, go to TX_DATA.
  - 1 (NACK) → WAIT_STOP.
- WAIT_STOP: SDA released; ignore all bits until START or STOP.

Bus conditions:
- STOP in any state → IDLE, SDA released, `busy` = 0.
- Repeated START in any state → ADDR, bit count cleared, SDA released, `busy` = 0.

## Timing
- Reset values: `i2c_sda` = 'z, `tx_req` = 0, `rx_valid` = 0, `rx_data` = 8'h00, `busy` = 0, state = IDLE, shifter = 0.
- Reset mid-transfer releases SDA asynchronously, the same cycle.
- Bus-to-decision latency is `SYNC_STAGES` + 1 clk cycles from a pin change to edge/START/STOP detection.
- `rx_valid` pulses exactly 1 cycle after detection of the 8th data SCL rising edge.
- `busy` rises in the same cycle ACK_ADDR is entered.
- SDA changes (ACK or data) appear 1 cycle after detection of the SCL falling edge. This satisfies the hold requirement through the synchronizer delay.
- `tx_req` and the MSB drive occur in the same cycle.
- Simultaneous START/STOP detection with a bit edge: START/STOP wins and the bit is discarded.

## Structure
- Package `i2c_slave_pkg`: `st_e` enum (IDLE, ADDR, ACK_ADDR, RX_DATA, ACK_RX, TX_DATA, MACK, WAIT_STOP) and the bit-count width constant.
- Sub-module `i2c_line_sync`: `SYNC_STAGES` synchronizer plus rise/fall detection for one line, instantiated for SCL and for SDA.
- Top level: FSM, 8-bit shifter, 3-bit bit counter, open-drain SDA assignment.

## Test plan
- Write to 7'h50, data 8'hA5 then 8'h3C, STOP → ACK low on all three 9th clocks; `rx_valid` pulses twice with `rx_data` 8'hA5 then 8'h3C; `busy` falls after STOP.
- Address 7'h51 write → SDA stays released on the 9th clock; no `rx_valid`; `busy` stays 0; the next START to 7'h50 is ACKed.
- Read from 7'h50 with `tx_data` = 8'hC3, master ACK, `tx_data` = 8'h0F, master NACK, STOP → bus carries C3 then 0F MSB-first; `tx_req` pulses twice; SDA released after NACK.
- Repeated START after the 4th bit of a write byte, then read from 7'h50 → no `rx_valid` for the partial byte; the read completes correctly.
- Assert `reset` while driving a 0 data bit in TX_DATA → SDA immediately 'z; all outputs at reset values; the next transaction works.
- General call 7'h00 write → NACK and no `rx_valid`.
